// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Holds ALU inputs for a settle window, then returns the tagged result on a valid/ready channel.
module alu_req_arbiter #(
   parameter int DW            = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [2:0]      req_op0,
   input  logic [2:0]      req_op1,
   input  logic [DW-1:0]   req_a0,
   input  logic [DW-1:0]   req_a1,
   input  logic [DW-1:0]   req_b0,
   input  logic [DW-1:0]   req_b1,
   output logic [DW-1:0]   alu_inp1,
   output logic [DW-1:0]   alu_inp2,
   output logic [2:0]      alu_op_code,
   input  logic [2*DW-1:0] alu_result,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [2*DW-1:0] rsp_result,
   output logic            rsp_err,
   output logic            busy
);

   localparam int         CW     = 4;
   localparam logic [2:0] OP_DIV = 3'b011;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic            last_grant;
   logic            grant;
   logic            id_q;
   logic [CW-1:0]   settle_cnt;
   logic [2:0]      sel_op;
   logic [DW-1:0]   sel_a;
   logic [DW-1:0]   sel_b;
   logic            accept;
   logic            capture;
   logic            div_zero;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
      sel_op   = grant ? req_op1 : req_op0;
      sel_a    = grant ? req_a1  : req_a0;
      sel_b    = grant ? req_b1  : req_b0;
      div_zero = (sel_op == OP_DIV) && (sel_b == '0);
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 2'b00;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst && (req_valid != 2'b00)) begin
               accept    = 1'b1;
               req_ready = grant ? 2'b10 : 2'b01;
               state_d   = div_zero ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if (settle_cnt == '0) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The ALU registers double as the command latch; they are cleared on capture so
   // the ALU sees zeros outside the settle window.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant  <= 1'b1;
         id_q        <= 1'b0;
         settle_cnt  <= '0;
         alu_inp1    <= '0;
         alu_inp2    <= '0;
         alu_op_code <= '0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_err     <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= grant;
            id_q       <= grant;
            if (div_zero) begin
               rsp_id     <= grant;
               rsp_result <= '0;
               rsp_err    <= 1'b1;
            end else begin
               alu_inp1    <= sel_a;
               alu_inp2    <= sel_b;
               alu_op_code <= sel_op;
               settle_cnt  <= CW'(SETTLE_CYCLES - 1);
            end
         end
         if (state_q == ISSUE) begin
            if (capture) begin
               rsp_result  <= alu_result;
               rsp_err     <= 1'b0;
               rsp_id      <= id_q;
               alu_inp1    <= '0;
               alu_inp2    <= '0;
               alu_op_code <= '0;
            end else begin
               settle_cnt <= settle_cnt - CW'(1);
            end
         end
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: three builds (settle 2, 1, 15) on shared stimulus, each with its own ALU,
// plus a transaction-level monitor on the settle-2 build.
module tb_alu_req_arbiter;

   localparam int SETTLE = 2;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [2:0]  req_op0, req_op1;
   logic [15:0] req_a0, req_a1, req_b0, req_b1;
   logic        rsp_ready;

   logic [1:0]  rdy  [3];
   logic [15:0] ai1  [3];
   logic [15:0] ai2  [3];
   logic [2:0]  aop  [3];
   logic [31:0] ares [3];
   logic        rv   [3];
   logic        rid  [3];
   logic [31:0] rres [3];
   logic        rerr [3];
   logic        bsy  [3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat_tab [3] = '{3, 2, 16};

   // Behavioural ALU: operands sign-extended, arithmetic in 32 bits.
   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      sa = int'(signed'(a));
      sb = int'(signed'(b));
      case (op)
         3'd0: return sa + sb;
         3'd1: return sa - sb;
         3'd2: return sa * sb;
         3'd3: return (sb == 0) ? 0 : sa / sb;
         3'd4: return sa | sb;
         3'd5: return sa & sb;
         3'd6: return ~sa;
         default: return ~sb;
      endcase
   endfunction

   assign ares[0] = alu_fn(aop[0], ai1[0], ai2[0]);
   assign ares[1] = alu_fn(aop[1], ai1[1], ai2[1]);
   assign ares[2] = alu_fn(aop[2], ai1[2], ai2[2]);

   alu_req_arbiter #(.DW(16), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1), .alu_inp1(ai1[0]), .alu_inp2(ai2[0]),
      .alu_op_code(aop[0]), .alu_result(ares[0]), .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
      .rsp_id(rid[0]), .rsp_result(rres[0]), .rsp_err(rerr[0]), .busy(bsy[0]));

   alu_req_arbiter #(.DW(16), .SETTLE_CYCLES(1)) dut_s1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1), .alu_inp1(ai1[1]), .alu_inp2(ai2[1]),
      .alu_op_code(aop[1]), .alu_result(ares[1]), .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
      .rsp_id(rid[1]), .rsp_result(rres[1]), .rsp_err(rerr[1]), .busy(bsy[1]));

   alu_req_arbiter #(.DW(16), .SETTLE_CYCLES(15)) dut_s15 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]),
      .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1), .alu_inp1(ai1[2]), .alu_inp2(ai2[2]),
      .alu_op_code(aop[2]), .alu_result(ares[2]), .rsp_valid(rv[2]), .rsp_ready(rsp_ready),
      .rsp_id(rid[2]), .rsp_result(rres[2]), .rsp_err(rerr[2]), .busy(bsy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Transaction-level reference: a queue of accepted commands, each with the cycle
   // its response becomes due; nothing is accepted while any command is outstanding.
   typedef struct {
      logic        id;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] res;
      logic        err;
      int          due;
   } pend_t;

   pend_t pq[$];
   logic  mlast = 1'b1;

   always @(negedge clk) begin : monitor
      logic [1:0] exp_ready;
      logic       g;
      bit         due_now;
      pend_t      p;
      if (rst) begin
         pq.delete();
         mlast = 1'b1;
      end else begin
         g         = (req_valid == 2'b11) ? ~mlast : req_valid[1];
         exp_ready = 2'b00;
         if (pq.size() == 0 && req_valid != 2'b00) exp_ready = g ? 2'b10 : 2'b01;
         chk("mon_req_ready", 32'(rdy[0]), 32'(exp_ready));
         chk("mon_busy", 32'(bsy[0]), 32'(pq.size() != 0));
         due_now = 1'b0;
         if (pq.size() != 0) due_now = (cyc >= pq[0].due);
         chk("mon_rsp_valid", 32'(rv[0]), 32'(due_now));
         if (due_now) begin
            chk("mon_rsp_id", 32'(rid[0]), 32'(pq[0].id));
            chk("mon_rsp_result", rres[0], pq[0].res);
            chk("mon_rsp_err", 32'(rerr[0]), 32'(pq[0].err));
         end
         if (pq.size() != 0 && !due_now) begin
            chk("mon_alu_inp1", 32'(ai1[0]), 32'(pq[0].a));
            chk("mon_alu_inp2", 32'(ai2[0]), 32'(pq[0].b));
            chk("mon_alu_op", 32'(aop[0]), 32'(pq[0].op));
         end else begin
            chk("mon_alu_idle", {ai1[0], ai2[0]} | 32'(aop[0]), 32'd0);
         end
         if (due_now && rsp_ready) void'(pq.pop_front());
         if (exp_ready != 2'b00) begin
            p.id  = g;
            p.op  = g ? req_op1 : req_op0;
            p.a   = g ? req_a1 : req_a0;
            p.b   = g ? req_b1 : req_b0;
            p.err = (p.op == 3'b011) && (p.b == 16'd0);
            p.res = p.err ? 32'd0 : alu_fn(p.op, p.a, p.b);
            p.due = p.err ? cyc + 1 : cyc + SETTLE + 1;
            pq.push_back(p);
            mlast = g;
         end
      end
   end

   typedef struct {
      logic        id;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] res;
      logic        err;
   } vec_t;

   vec_t vecs [12];

   task automatic set_cmd(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
      else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
   endtask

   task automatic reset_dut;
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   // One command to all three builds; measures each build's latency and response.
   task automatic run_one(input vec_t v);
      int          lat [3];
      logic [31:0] res [3];
      logic        er  [3];
      logic        ids [3];
      int          t0;
      bit          done;
      for (int k = 0; k < 3; k++) begin lat[k] = -1; res[k] = '0; er[k] = 1'b0; ids[k] = 1'b0; end
      set_cmd(1'b0, v.op, v.a, v.b);
      set_cmd(1'b1, v.op, v.a, v.b);
      req_valid = v.id ? 2'b10 : 2'b01;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("vec_ready", 32'(rdy[0]), v.id ? 32'd2 : 32'd1);
      t0 = cyc;
      tick;
      req_valid = 2'b00;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         done = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (rv[k] && lat[k] < 0) begin
               lat[k] = cyc - t0; res[k] = rres[k]; er[k] = rerr[k]; ids[k] = rid[k];
            end
            if (lat[k] < 0 || bsy[k]) done = 1'b0;
         end
         if (done) break;
         tick;
      end
      tick;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("vec_latency_b%0d", k), 32'(lat[k]), v.err ? 32'd1 : 32'(lat_tab[k]));
         chk($sformatf("vec_result_b%0d", k), res[k], v.res);
         chk($sformatf("vec_err_b%0d", k), 32'(er[k]), 32'(v.err));
         chk($sformatf("vec_id_b%0d", k), 32'(ids[k]), 32'(v.id));
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : main
      int gr [3];
      int ng;
      int late;
      int t0;
      logic [31:0] r0, r1;

      vecs[0]  = '{1'b0, 3'd0, 16'd5,     16'd3,     32'd8,         1'b0};
      vecs[1]  = '{1'b1, 3'd2, 16'd321,   16'd56,    32'd17976,     1'b0};
      vecs[2]  = '{1'b0, 3'd1, 16'd566,   16'hFE4B,  32'd1003,      1'b0};
      vecs[3]  = '{1'b1, 3'd3, 16'hFF0F,  16'd0,     32'd0,         1'b1};
      vecs[4]  = '{1'b0, 3'd4, 16'h000F,  16'h0C0A,  32'h00000C0F,  1'b0};
      vecs[5]  = '{1'b1, 3'd6, 16'h0C7A,  16'd9,     32'hFFFFF385,  1'b0};
      vecs[6]  = '{1'b0, 3'd5, 16'h0F0F,  16'h00FF,  32'h0000000F,  1'b0};
      vecs[7]  = '{1'b1, 3'd7, 16'd1234,  16'd0,     32'hFFFFFFFF,  1'b0};
      vecs[8]  = '{1'b0, 3'd3, 16'd100,   16'hFFF9,  32'hFFFFFFF2,  1'b0};
      vecs[9]  = '{1'b1, 3'd1, 16'd3,     16'd5,     32'hFFFFFFFE,  1'b0};
      vecs[10] = '{1'b0, 3'd2, 16'hFED4,  16'd200,   32'hFFFF15A0,  1'b0};
      vecs[11] = '{1'b0, 3'd3, 16'hFF0F,  16'd0,     32'd0,         1'b1};

      // Reset dominates: both requesters valid while rst is high.
      rst = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      set_cmd(1'b0, 3'd2, 16'd321, 16'd56);
      set_cmd(1'b1, 3'd1, 16'd566, 16'hFE4B);
      tick;
      tick;
      @(negedge clk);
      chk("reset_req_ready", 32'(rdy[0]), 32'd0);
      chk("reset_rsp_valid", 32'(rv[0]), 32'd0);
      chk("reset_busy", 32'(bsy[0]), 32'd0);
      chk("reset_alu", {ai1[0], ai2[0]} | 32'(aop[0]), 32'd0);
      chk("reset_rsp", rres[0] | 32'(rerr[0]) | 32'(rid[0]), 32'd0);
      tick;
      rst = 1'b0;
      req_valid = 2'b00;
      @(negedge clk);
      chk("post_reset_busy", 32'(bsy[0]), 32'd0);
      tick;

      $display("[TB] table vectors");
      for (int i = 0; i < 12; i++) run_one(vecs[i]);

      $display("[TB] fairness");
      reset_dut;
      set_cmd(1'b0, 3'd2, 16'd321, 16'd56);
      set_cmd(1'b1, 3'd1, 16'd566, 16'hFE4B);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      gr = '{-1, -1, -1};
      ng = 0;
      r0 = '0;
      r1 = '0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (rdy[0] != 2'b00 && ng < 3) begin gr[ng] = int'(rdy[0][1]); ng++; end
         if (rv[0]) begin
            if (rid[0]) r1 = rres[0];
            else        r0 = rres[0];
         end
         if (ng == 3) break;
         tick;
      end
      tick;
      req_valid = 2'b00;
      chk("fair_grant0", 32'(gr[0]), 32'd0);
      chk("fair_grant1", 32'(gr[1]), 32'd1);
      chk("fair_grant2", 32'(gr[2]), 32'd0);
      chk("fair_result_id0", r0, 32'd17976);
      chk("fair_result_id1", r1, 32'd1003);

      $display("[TB] stall");
      reset_dut;
      set_cmd(1'b0, 3'd4, 16'h000F, 16'h0C0A);
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      @(negedge clk);
      t0 = cyc;
      chk("stall_accept", 32'(rdy[0]), 32'd1);
      tick;
      set_cmd(1'b0, 3'd0, 16'd1, 16'd1);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rv[0]) break;
         tick;
      end
      chk("stall_latency", 32'(cyc - t0), 32'd3);
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(rv[0]), 32'd1);
         chk("stall_result", rres[0], 32'h00000C0F);
         chk("stall_ready", 32'(rdy[0]), 32'd0);
         tick;
         @(negedge clk);
      end
      tick;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hs_valid", 32'(rv[0]), 32'd1);
      chk("hs_ready", 32'(rdy[0]), 32'd0);
      tick;
      @(negedge clk);
      chk("post_hs_ready", 32'(rdy[0]), 32'd1);
      chk("post_hs_valid", 32'(rv[0]), 32'd0);
      tick;
      req_valid = 2'b00;

      $display("[TB] reset during issue");
      reset_dut;
      set_cmd(1'b0, 3'd2, 16'd321, 16'd56);
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      @(negedge clk);
      tick;
      req_valid = 2'b00;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_reset_busy", 32'(bsy[0]), 32'd0);
      chk("mid_reset_valid", 32'(rv[0]), 32'd0);
      chk("mid_reset_alu", {ai1[0], ai2[0]} | 32'(aop[0]), 32'd0);
      chk("mid_reset_rsp", rres[0] | 32'(rerr[0]) | 32'(rid[0]), 32'd0);
      late = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rv[0]) late++;
         tick;
      end
      chk("mid_reset_no_rsp", 32'(late), 32'd0);
      set_cmd(1'b1, 3'd1, 16'd566, 16'hFE4B);
      req_valid = 2'b11;
      @(negedge clk);
      chk("tie_after_reset", 32'(rdy[0]), 32'd1);
      tick;
      req_valid = 2'b00;

      $display("[TB] random traffic");
      reset_dut;
      for (int n = 0; n < 600; n++) begin
         req_valid = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0)
            set_cmd(1'b0, 3'($urandom_range(0, 7)), 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
         if ($urandom_range(0, 2) == 0)
            set_cmd(1'b1, 3'($urandom_range(0, 7)), 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick;
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (pq.size() == 0) break;
         tick;
      end
      tick;
      chk("drain_outstanding", 32'(pq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
